// File: rtl/nonce_range_scheduler_pkg.sv
// nonce_pkg
// Shared definitions for the nonce range scheduler: the two-state job FSM
// encoding and the default nonce width / lane count used by the top level
// and its interface.
package nonce_pkg;

  // Job state: IDLE waits for a start pulse, RUN is issuing nonces.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int NONCE_WIDTH = 32;
  localparam int NONCE_CORES = 4;

endpackage

// File: rtl/nonce_range_scheduler_if.sv
// nonce_range_scheduler_if
// Bundles the per-lane nonce handshake between the scheduler and the core
// array.
//   nonce_out   : NUM_CORES*WIDTH, lane k in bits [k*WIDTH +: WIDTH]
//   nonce_valid : per-lane valid, driven by the scheduler
//   nonce_ready : per-lane ready, driven by the hashing cores
// The master modport is the scheduler side, the slave modport the core side.
interface nonce_range_scheduler_if
  import nonce_pkg::*;
#(
  parameter int WIDTH     = NONCE_WIDTH,
  parameter int NUM_CORES = NONCE_CORES
);

  logic [NUM_CORES*WIDTH-1:0] nonce_out;
  logic [NUM_CORES-1:0]       nonce_valid;
  logic [NUM_CORES-1:0]       nonce_ready;

  modport master (
    output nonce_out,
    output nonce_valid,
    input  nonce_ready
  );

  modport slave (
    input  nonce_out,
    input  nonce_valid,
    output nonce_ready
  );

endinterface

// File: rtl/nonce_range_scheduler_lane.sv
// nonce_lane
// One interleaved nonce lane. On load it starts at base+LANE; every accepted
// handshake steps it by STRIDE until the next value would pass the limit or
// leave the WIDTH-bit nonce space, at which point the lane retires.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   load_i       : start of a job; base_i/limit_i are sampled this cycle
//   kill_i       : abort/found; drops valid, nonce holds
//   ready_i      : core ready for this lane
//   base_i       : range base (only used on load)
//   limit_i      : inclusive range limit for the current compare
//   nonce_o      : current nonce
//   valid_o      : lane has a nonce on offer
//   active_o     : lane will still be valid after this clock edge
//   fire_o       : handshake this cycle (valid & ready)
module nonce_lane #(
  parameter int WIDTH  = 32,
  parameter int STRIDE = 4,
  parameter int LANE   = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic             kill_i,
  input  logic             ready_i,
  input  logic [WIDTH-1:0] base_i,
  input  logic [WIDTH-1:0] limit_i,
  output logic [WIDTH-1:0] nonce_o,
  output logic             valid_o,
  output logic             active_o,
  output logic             fire_o
);

  localparam logic [WIDTH:0] LaneOffset = (WIDTH+1)'(LANE);
  localparam logic [WIDTH:0] StrideStep = (WIDTH+1)'(STRIDE);

  logic [WIDTH-1:0] nonce_q, nonce_d;
  logic             valid_q, valid_d;
  logic [WIDTH:0]   loadSum, stepSum;
  logic             loadOk, stepOk;

  // Next-state for the lane. Sums are one bit wider than the nonce so that a
  // carry out of the nonce space retires the lane instead of wrapping to a
  // small value that would compare below the limit.
  always_comb begin
    loadSum  = {1'b0, base_i} + LaneOffset;
    stepSum  = {1'b0, nonce_q} + StrideStep;
    loadOk   = !loadSum[WIDTH] && (loadSum[WIDTH-1:0] <= limit_i);
    stepOk   = !stepSum[WIDTH] && (stepSum[WIDTH-1:0] <= limit_i);
    fire_o   = valid_q & ready_i;
    nonce_d  = nonce_q;
    valid_d  = valid_q;
    if (kill_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      nonce_d = loadSum[WIDTH-1:0];
      valid_d = loadOk;
    end else if (fire_o) begin
      if (stepOk) begin
        nonce_d = stepSum[WIDTH-1:0];
      end else begin
        valid_d = 1'b0;
      end
    end
    active_o = valid_d;
  end

  // Lane registers; a retired lane keeps its last nonce on the bus.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      nonce_q <= '0;
      valid_q <= 1'b0;
    end else begin
      nonce_q <= nonce_d;
      valid_q <= valid_d;
    end
  end

  assign nonce_o = nonce_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/nonce_range_scheduler.sv
// nonce_range_scheduler
// Splits the inclusive nonce range [base, limit] over NUM_CORES lanes, lane k
// issuing base+k, base+k+NUM_CORES, ... with per-lane valid/ready flow
// control. Handles early stop on found, abort, and exhaustion reporting.
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   start         : one-cycle pulse, accepted only in IDLE (and not with abort)
//   abort         : cancel the running job, no done pulse
//   found         : a core hit; stop issuing and end the job with done
//   base, limit   : inclusive nonce range, latched on accepted start
//   busy          : high while a job is running
//   done          : one-cycle pulse when a job ends by exhaustion or found
//   exhausted     : sticky, set when the range completed without found
//   issued_count  : handshakes in the current job
//   bus           : per-lane nonce/valid/ready bundle (master side)
module nonce_range_scheduler
  import nonce_pkg::*;
#(
  parameter int WIDTH     = NONCE_WIDTH,
  parameter int NUM_CORES = NONCE_CORES
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  found,
  input  logic [WIDTH-1:0]      base,
  input  logic [WIDTH-1:0]      limit,
  output logic                  busy,
  output logic                  done,
  output logic                  exhausted,
  output logic [WIDTH:0]        issued_count,
  nonce_range_scheduler_if.master bus
);

  state_e                     state_q, state_d;
  logic                       done_q, done_d;
  logic                       exhausted_q, exhausted_d;
  logic [WIDTH:0]             issued_q, issued_d;
  logic [WIDTH-1:0]           limit_q, limit_d;

  logic                       laneLoad, laneKill, exhaustSet;
  logic [WIDTH-1:0]           laneLimit;
  logic [NUM_CORES-1:0]       laneValid, laneActive, laneFire;
  logic [NUM_CORES*WIDTH-1:0] nonceFlat;
  logic [WIDTH:0]             fireCount;

  // Lanes see the incoming limit in the load cycle (limit_q is not yet
  // written) and the latched copy for the rest of the job.
  assign laneLimit = laneLoad ? limit : limit_q;

  for (genvar k = 0; k < NUM_CORES; k++) begin : g_lane
    nonce_lane #(
      .WIDTH  (WIDTH),
      .STRIDE (NUM_CORES),
      .LANE   (k)
    ) u_lane (
      .clk      (clk),
      .reset_n  (reset_n),
      .load_i   (laneLoad),
      .kill_i   (laneKill),
      .ready_i  (bus.nonce_ready[k]),
      .base_i   (base),
      .limit_i  (laneLimit),
      .nonce_o  (nonceFlat[k*WIDTH +: WIDTH]),
      .valid_o  (laneValid[k]),
      .active_o (laneActive[k]),
      .fire_o   (laneFire[k])
    );
  end

  assign bus.nonce_out   = nonceFlat;
  assign bus.nonce_valid = laneValid;

  // Job FSM. Abort beats found, and both beat exhaustion in the same cycle.
  // Exhaustion looks at the lanes' post-edge activity so done lands in the
  // cycle right after the last retirement, with busy already low.
  always_comb begin
    state_d    = state_q;
    done_d     = 1'b0;
    exhaustSet = 1'b0;
    laneLoad   = 1'b0;
    laneKill   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          laneLoad = 1'b1;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          laneKill = 1'b1;
          state_d  = ST_IDLE;
        end else if (found) begin
          laneKill = 1'b1;
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end else if (!(|laneActive)) begin
          done_d     = 1'b1;
          exhaustSet = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake counter, sticky exhausted flag and the latched limit. A
  // handshake in the same cycle as found/abort is still counted because
  // fire does not depend on the kill.
  always_comb begin
    fireCount = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      fireCount = fireCount + (WIDTH+1)'(laneFire[k]);
    end
    issued_d    = laneLoad ? '0 : issued_q + fireCount;
    exhausted_d = exhausted_q;
    if (laneLoad) begin
      exhausted_d = 1'b0;
    end else if (exhaustSet) begin
      exhausted_d = 1'b1;
    end
    limit_d = laneLoad ? limit : limit_q;
  end

  // Control-path registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      done_q      <= 1'b0;
      exhausted_q <= 1'b0;
      issued_q    <= '0;
      limit_q     <= '0;
    end else begin
      state_q     <= state_d;
      done_q      <= done_d;
      exhausted_q <= exhausted_d;
      issued_q    <= issued_d;
      limit_q     <= limit_d;
    end
  end

  assign busy         = (state_q == ST_RUN);
  assign done         = done_q;
  assign exhausted    = exhausted_q;
  assign issued_count = issued_q;

endmodule

// File: tb/tb_nonce_range_scheduler.sv
// tb_nonce_range_scheduler
// Directed bench: a 32-bit/4-lane instance for partition, backpressure,
// found, abort, empty-range and reset cases, and an 8-bit/3-lane instance
// for the top-of-space range. Expected values are hand-computed.
module tb_nonce_range_scheduler;

  logic clk = 1'b0;
  logic reset_n;

  logic        start32, abort32, found32;
  logic [31:0] base32, limit32;
  logic        busy32, done32, exh32;
  logic [32:0] count32;

  logic        start8, abort8, found8;
  logic [7:0]  base8, limit8;
  logic        busy8, done8, exh8;
  logic [8:0]  count8;

  int total = 0;
  int bad   = 0;

  nonce_range_scheduler_if #(.WIDTH(32), .NUM_CORES(4)) bus32 ();
  nonce_range_scheduler_if #(.WIDTH(8),  .NUM_CORES(3)) bus8 ();

  nonce_range_scheduler #(.WIDTH(32), .NUM_CORES(4)) dut32 (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start32),
    .abort        (abort32),
    .found        (found32),
    .base         (base32),
    .limit        (limit32),
    .busy         (busy32),
    .done         (done32),
    .exhausted    (exh32),
    .issued_count (count32),
    .bus          (bus32.master)
  );

  nonce_range_scheduler #(.WIDTH(8), .NUM_CORES(3)) dut8 (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start8),
    .abort        (abort8),
    .found        (found8),
    .base         (base8),
    .limit        (limit8),
    .busy         (busy8),
    .done         (done8),
    .exhausted    (exh8),
    .issued_count (count8),
    .bus          (bus8.master)
  );

  always #5 clk = ~clk;

  // One row describes the outputs expected in a cycle and the ready mask
  // presented to the 32-bit instance during that cycle.
  typedef struct packed {
    logic [3:0]       ready;
    logic [3:0]       expValid;
    logic [3:0][31:0] expNonce;
    logic             expBusy;
    logic             expDone;
    logic             expExh;
    logic [32:0]      expCount;
  } vec_t;

  vec_t vecs [14];

  function automatic vec_t mkVec(input logic [3:0] rdy, input logic [3:0] vld,
                                 input int n0, input int n1, input int n2, input int n3,
                                 input logic b, input logic d, input logic e, input int cnt);
    vec_t v;
    v.ready       = rdy;
    v.expValid    = vld;
    v.expNonce[0] = 32'(n0);
    v.expNonce[1] = 32'(n1);
    v.expNonce[2] = 32'(n2);
    v.expNonce[3] = 32'(n3);
    v.expBusy     = b;
    v.expDone     = d;
    v.expExh      = e;
    v.expCount    = 33'(cnt);
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] rdy, input logic s, input logic a, input logic f);
    bus32.nonce_ready = rdy;
    start32 = s;
    abort32 = a;
    found32 = f;
  endtask

  // Pulse start on the 32-bit instance; returns #1 into cycle N+1.
  task automatic startJob32(input logic [31:0] b, input logic [31:0] l);
    base32  = b;
    limit32 = l;
    applyStimulus(4'hF, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    start32 = 1'b0;
  endtask

  task automatic checkRow(input int i);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("row%0d nonce%0d", i, k),
                  64'(bus32.nonce_out[k*32 +: 32]), 64'(vecs[i].expNonce[k]));
    end
    checkOutput($sformatf("row%0d valid", i), 64'(bus32.nonce_valid), 64'(vecs[i].expValid));
    checkOutput($sformatf("row%0d busy", i),  64'(busy32),  64'(vecs[i].expBusy));
    checkOutput($sformatf("row%0d done", i),  64'(done32),  64'(vecs[i].expDone));
    checkOutput($sformatf("row%0d exh", i),   64'(exh32),   64'(vecs[i].expExh));
    checkOutput($sformatf("row%0d count", i), 64'(count32), 64'(vecs[i].expCount));
  endtask

  task automatic runRows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      checkRow(i);
      applyStimulus(vecs[i].ready, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    // Basic partition, base=100 limit=109, all ready.
    vecs[0]  = mkVec(4'hF, 4'b1111, 100, 101, 102, 103, 1, 0, 0, 0);
    vecs[1]  = mkVec(4'hF, 4'b1111, 104, 105, 106, 107, 1, 0, 0, 4);
    vecs[2]  = mkVec(4'hF, 4'b0011, 108, 109, 106, 107, 1, 0, 0, 8);
    vecs[3]  = mkVec(4'hF, 4'b0000, 108, 109, 106, 107, 0, 1, 1, 10);
    vecs[4]  = mkVec(4'hF, 4'b0000, 108, 109, 106, 107, 0, 0, 1, 10);
    // Backpressure: lane 1 not ready for 5 cycles.
    vecs[5]  = mkVec(4'b1101, 4'b1111, 100, 101, 102, 103, 1, 0, 0, 0);
    vecs[6]  = mkVec(4'b1101, 4'b1111, 104, 101, 106, 107, 1, 0, 0, 3);
    vecs[7]  = mkVec(4'b1101, 4'b0011, 108, 101, 106, 107, 1, 0, 0, 6);
    vecs[8]  = mkVec(4'b1101, 4'b0010, 108, 101, 106, 107, 1, 0, 0, 7);
    vecs[9]  = mkVec(4'b1101, 4'b0010, 108, 101, 106, 107, 1, 0, 0, 7);
    vecs[10] = mkVec(4'b1111, 4'b0010, 108, 101, 106, 107, 1, 0, 0, 7);
    vecs[11] = mkVec(4'b1111, 4'b0010, 108, 105, 106, 107, 1, 0, 0, 8);
    vecs[12] = mkVec(4'b1111, 4'b0010, 108, 109, 106, 107, 1, 0, 0, 9);
    vecs[13] = mkVec(4'b1111, 4'b0000, 108, 109, 106, 107, 0, 1, 1, 10);

    reset_n = 1'b0;
    applyStimulus(4'hF, 1'b0, 1'b0, 1'b0);
    base32 = '0; limit32 = '0;
    start8 = 1'b0; abort8 = 1'b0; found8 = 1'b0;
    base8 = '0; limit8 = '0;
    bus8.nonce_ready = 3'b111;
    #2;
    checkOutput("reset busy",  64'(busy32), 64'd0);
    checkOutput("reset done",  64'(done32), 64'd0);
    checkOutput("reset exh",   64'(exh32), 64'd0);
    checkOutput("reset count", 64'(count32), 64'd0);
    checkOutput("reset valid", 64'(bus32.nonce_valid), 64'd0);
    checkOutput("reset nonce", 64'(bus32.nonce_out[63:0]), 64'd0);
    #10 reset_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] basic partition");
    startJob32(32'd100, 32'd109);
    runRows(0, 4);

    $display("[TB] backpressure");
    base32 = 32'd100; limit32 = 32'd109;
    applyStimulus(4'b1101, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    start32 = 1'b0;
    runRows(5, 13);

    $display("[TB] early found");
    startJob32(32'd0, 32'd1000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("found run valid",  64'(bus32.nonce_valid), 64'hF);
    checkOutput("found run nonce0", 64'(bus32.nonce_out[31:0]), 64'd8);
    checkOutput("found run nonce3", 64'(bus32.nonce_out[127:96]), 64'd11);
    found32 = 1'b1;
    @(posedge clk); #1;
    found32 = 1'b0;
    checkOutput("found valid", 64'(bus32.nonce_valid), 64'd0);
    checkOutput("found busy",  64'(busy32), 64'd0);
    checkOutput("found done",  64'(done32), 64'd1);
    checkOutput("found exh",   64'(exh32), 64'd0);
    checkOutput("found count", 64'(count32), 64'd12);
    @(posedge clk); #1;
    checkOutput("found done once", 64'(done32), 64'd0);

    $display("[TB] start ignored in run, abort");
    startJob32(32'd0, 32'd1000);
    checkOutput("abort count cleared", 64'(count32), 64'd0);
    base32  = 32'd500;
    start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    checkOutput("restart nonce0", 64'(bus32.nonce_out[31:0]), 64'd4);
    checkOutput("restart count",  64'(count32), 64'd4);
    checkOutput("restart busy",   64'(busy32), 64'd1);
    abort32 = 1'b1;
    @(posedge clk); #1;
    abort32 = 1'b0;
    checkOutput("abort valid", 64'(bus32.nonce_valid), 64'd0);
    checkOutput("abort busy",  64'(busy32), 64'd0);
    checkOutput("abort done",  64'(done32), 64'd0);
    checkOutput("abort count", 64'(count32), 64'd8);
    @(posedge clk); #1;
    checkOutput("abort done later", 64'(done32), 64'd0);
    found32 = 1'b1;
    @(posedge clk); #1;
    found32 = 1'b0;
    checkOutput("idle found done", 64'(done32), 64'd0);
    checkOutput("idle found busy", 64'(busy32), 64'd0);

    $display("[TB] empty range");
    startJob32(32'd20, 32'd10);
    checkOutput("empty busy n+1",  64'(busy32), 64'd1);
    checkOutput("empty valid n+1", 64'(bus32.nonce_valid), 64'd0);
    checkOutput("empty done n+1",  64'(done32), 64'd0);
    @(posedge clk); #1;
    checkOutput("empty done",  64'(done32), 64'd1);
    checkOutput("empty exh",   64'(exh32), 64'd1);
    checkOutput("empty busy",  64'(busy32), 64'd0);
    checkOutput("empty valid", 64'(bus32.nonce_valid), 64'd0);
    checkOutput("empty count", 64'(count32), 64'd0);

    $display("[TB] top of space");
    base8 = 8'd250; limit8 = 8'd255; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    checkOutput("top valid c1", 64'(bus8.nonce_valid), 64'd7);
    checkOutput("top lane0 c1", 64'(bus8.nonce_out[7:0]), 64'd250);
    checkOutput("top lane1 c1", 64'(bus8.nonce_out[15:8]), 64'd251);
    checkOutput("top lane2 c1", 64'(bus8.nonce_out[23:16]), 64'd252);
    @(posedge clk); #1;
    checkOutput("top valid c2", 64'(bus8.nonce_valid), 64'd7);
    checkOutput("top lane0 c2", 64'(bus8.nonce_out[7:0]), 64'd253);
    checkOutput("top lane1 c2", 64'(bus8.nonce_out[15:8]), 64'd254);
    checkOutput("top lane2 c2", 64'(bus8.nonce_out[23:16]), 64'd255);
    @(posedge clk); #1;
    checkOutput("top valid end", 64'(bus8.nonce_valid), 64'd0);
    checkOutput("top done",  64'(done8), 64'd1);
    checkOutput("top exh",   64'(exh8), 64'd1);
    checkOutput("top count", 64'(count8), 64'd6);

    $display("[TB] async reset mid-job");
    startJob32(32'd0, 32'd1000);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    checkOutput("arst valid", 64'(bus32.nonce_valid), 64'd0);
    checkOutput("arst nonce", 64'(bus32.nonce_out[63:0]), 64'd0);
    checkOutput("arst busy",  64'(busy32), 64'd0);
    checkOutput("arst count", 64'(count32), 64'd0);
    checkOutput("arst exh",   64'(exh32), 64'd0);
    checkOutput("arst exh8",  64'(exh8), 64'd0);
    #2 reset_n = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("post reset busy",  64'(busy32), 64'd0);
    checkOutput("post reset valid", 64'(bus32.nonce_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
